// File: rtl/frame_deserializer_pkg.sv
// Shared types and constants for the frame deserializer.
//   fd_state_t : frame-layer FSM states
//   ERR_*      : codes reported on err_code_out
package frame_deserializer_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } fd_state_t;

  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_OVF     = 2'd3;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/uart_receive.sv
// 8N1 UART receiver, LSB first.
//   clk_in     : system clock
//   rst_in     : asynchronous reset, active-high
//   rx_wire_in : serial line (idle high)
//   valid_out  : one-cycle pulse when a byte with a valid stop bit arrives
//   data_out   : received byte, stable while the receiver is idle
module uart_receive #(
  parameter int BAUD_RATE        = 9600,
  parameter int INPUT_CLOCK_FREQ = 100_000_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_wire_in,
  output logic       valid_out,
  output logic [7:0] data_out
);

  localparam int CPB   = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 2;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} u_state_t;

  u_state_t           state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         sh_q, sh_d;
  logic               valid_q, valid_d;
  logic               rx_s1_q, rx_s2_q;

  // Two-flop synchronizer; reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_wire_in;
      rx_s2_q <= rx_s1_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= U_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    case (state_q)
      U_IDLE: begin
        if (!rx_s2_q) begin
          state_d = U_START;
          cnt_d   = '0;
        end
      end
      U_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Re-check the line half a bit in; a glitch returns to idle.
        if (cnt_q == CNT_W'(CPB / 2 - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx_s2_q ? U_IDLE : U_DATA;
        end
      end
      U_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_s2_q, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = U_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      U_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d   = '0;
          state_d = U_IDLE;
          valid_d = rx_s2_q;  // framing error: byte silently discarded
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

  assign valid_out = valid_q;
  assign data_out  = sh_q;

endmodule

// File: rtl/frame_deserializer.sv
// UART-fed frame receiver producing {message, exponent, modulus} for the RSA datapath.
// Frame: SYNC_BYTE, P = MSG_BYTES + 2*KEY_BYTES payload bytes, XOR checksum byte.
//   clk_in       : system clock
//   rst_in       : asynchronous reset, active-high
//   rx_wire_in   : UART serial line (idle high)
//   ready_in     : consumer accepts the held frame when valid_out && ready_in
//   valid_out    : held frame available
//   message_out  : message field   (8*MSG_BYTES)
//   exponent_out : exponent field  (8*KEY_BYTES)
//   modulus_out  : modulus field   (8*KEY_BYTES)
//   err_out      : one-cycle error pulse
//   err_code_out : 1 timeout, 2 checksum, 3 overflow; held until the next error
module frame_deserializer
  import frame_deserializer_pkg::*;
#(
  parameter int         MSG_BYTES        = 2,
  parameter int         KEY_BYTES        = 4,
  parameter int         BAUD_RATE        = 9600,
  parameter int         INPUT_CLOCK_FREQ = 100_000_000,
  parameter logic [7:0] SYNC_BYTE        = 8'hA5,
  parameter int         TIMEOUT_CYCLES   = 100_000,
  parameter int         BYTE_ORDER       = 0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rx_wire_in,
  input  logic                   ready_in,
  output logic                   valid_out,
  output logic [8*MSG_BYTES-1:0] message_out,
  output logic [8*KEY_BYTES-1:0] exponent_out,
  output logic [8*KEY_BYTES-1:0] modulus_out,
  output logic                   err_out,
  output logic [1:0]             err_code_out
);

  localparam int P     = MSG_BYTES + 2 * KEY_BYTES;
  localparam int BUF_W = BYTE_W * P;
  localparam int KEY_W = BYTE_W * KEY_BYTES;
  localparam int MSG_W = BYTE_W * MSG_BYTES;
  localparam int IDX_W = $clog2(P);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic             rx_vld;
  logic [7:0]       rx_byte;

  fd_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [7:0]       csum_q, csum_d;

  logic             valid_q, valid_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [KEY_W-1:0] exp_q, exp_d;
  logic [KEY_W-1:0] mod_q, mod_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             commit;
  logic             err_set;
  logic [1:0]       err_set_code;
  logic [IDX_W-1:0] slot;

  uart_receive #(
    .BAUD_RATE       (BAUD_RATE),
    .INPUT_CLOCK_FREQ(INPUT_CLOCK_FREQ)
  ) u_uart (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rx_wire_in(rx_wire_in),
    .valid_out (rx_vld),
    .data_out  (rx_byte)
  );

  // BYTE_ORDER 1 fills from the top of the buffer so the first byte lands in the message MSB.
  assign slot = (BYTE_ORDER != 0) ? (IDX_W'(P - 1) - idx_q) : idx_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= HUNT;
      idx_q      <= '0;
      to_cnt_q   <= '0;
      buf_q      <= '0;
      csum_q     <= '0;
      valid_q    <= 1'b0;
      msg_q      <= '0;
      exp_q      <= '0;
      mod_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      to_cnt_q   <= to_cnt_d;
      buf_q      <= buf_d;
      csum_q     <= csum_d;
      valid_q    <= valid_d;
      msg_q      <= msg_d;
      exp_q      <= exp_d;
      mod_q      <= mod_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Frame-layer FSM: hunting, payload assembly, checksum, inter-byte timeout.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    to_cnt_d     = to_cnt_q;
    buf_d        = buf_q;
    csum_d       = csum_q;
    commit       = 1'b0;
    err_set      = 1'b0;
    err_set_code = ERR_TIMEOUT;
    case (state_q)
      HUNT: begin
        to_cnt_d = '0;
        if (rx_vld && (rx_byte == SYNC_BYTE)) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          buf_d   = '0;
          csum_d  = '0;
        end
      end
      PAYLOAD, CHECK: begin
        if (rx_vld) begin
          to_cnt_d = '0;
          if (state_q == PAYLOAD) begin
            buf_d[BYTE_W*slot +: BYTE_W] = rx_byte;
            csum_d = csum_q ^ rx_byte;
            if (idx_q == IDX_W'(P - 1)) state_d = CHECK;
            else                        idx_d   = idx_q + IDX_W'(1);
          end else begin
            state_d = HUNT;
            if (rx_byte == csum_q) begin
              commit = 1'b1;
            end else begin
              err_set      = 1'b1;
              err_set_code = ERR_CSUM;
            end
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // This cycle is the TIMEOUT_CYCLES-th without a byte.
          to_cnt_d     = '0;
          state_d      = HUNT;
          err_set      = 1'b1;
          err_set_code = ERR_TIMEOUT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Output hold register and valid/ready handshake.
  always_comb begin
    valid_d    = valid_q;
    msg_d      = msg_q;
    exp_d      = exp_q;
    mod_d      = mod_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    if (commit && !(valid_q && !ready_in)) begin
      valid_d = 1'b1;
      msg_d   = buf_q[BUF_W-1 -: MSG_W];
      exp_d   = buf_q[2*KEY_W-1 -: KEY_W];
      mod_d   = buf_q[KEY_W-1:0];
    end else if (commit) begin
      // Consumer still holds the previous frame: keep it, drop the new one.
      err_d      = 1'b1;
      err_code_d = ERR_OVF;
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
    if (err_set) begin
      err_d      = 1'b1;
      err_code_d = err_set_code;
    end
  end

  assign valid_out    = valid_q;
  assign message_out  = msg_q;
  assign exponent_out = exp_q;
  assign modulus_out  = mod_q;
  assign err_out      = err_q;
  assign err_code_out = err_code_q;

endmodule

// File: tb/tb_frame_deserializer.sv
`timescale 1ns/1ps
module tb_frame_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic rdy = 1'b1;

  logic       vld0, vld1, err0, err1;
  logic [7:0] msg0, exp0, mod0, msg1, exp1, mod1;
  logic [1:0] code0, code1;

  always #5 clk = ~clk;

  frame_deserializer #(
    .MSG_BYTES(1), .KEY_BYTES(1), .BAUD_RATE(10_000_000), .INPUT_CLOCK_FREQ(100_000_000),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(2000), .BYTE_ORDER(0)
  ) u_dut0 (
    .clk_in(clk), .rst_in(rst), .rx_wire_in(rx), .ready_in(rdy), .valid_out(vld0),
    .message_out(msg0), .exponent_out(exp0), .modulus_out(mod0),
    .err_out(err0), .err_code_out(code0)
  );

  frame_deserializer #(
    .MSG_BYTES(1), .KEY_BYTES(1), .BAUD_RATE(10_000_000), .INPUT_CLOCK_FREQ(100_000_000),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(2000), .BYTE_ORDER(1)
  ) u_dut1 (
    .clk_in(clk), .rst_in(rst), .rx_wire_in(rx), .ready_in(rdy), .valid_out(vld1),
    .message_out(msg1), .exponent_out(exp1), .modulus_out(mod1),
    .err_out(err1), .err_code_out(code1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Observed accepted frames ({msg,exp,mod}) and error codes, per instance.
  logic [23:0] acc0[$], acc1[$];
  logic [1:0]  errq0[$], errq1[$];
  logic        pv0 = 1'b0, pv1 = 1'b0, prdy = 1'b0;
  logic [23:0] pf0 = '0, pf1 = '0;

  always @(negedge clk) begin
    if (rst) begin
      pv0 <= 1'b0;
      pv1 <= 1'b0;
    end else begin
      if (pv0 && !prdy) begin
        chk("hold0_valid", vld0, 1);
        chk("hold0_fields", {msg0, exp0, mod0}, pf0);
      end
      if (pv1 && !prdy) begin
        chk("hold1_valid", vld1, 1);
        chk("hold1_fields", {msg1, exp1, mod1}, pf1);
      end
      if (vld0 && rdy) acc0.push_back({msg0, exp0, mod0});
      if (vld1 && rdy) acc1.push_back({msg1, exp1, mod1});
      if (err0) errq0.push_back(code0);
      if (err1) errq1.push_back(code1);
      pv0  <= vld0;
      pv1  <= vld1;
      prdy <= rdy;
      pf0  <= {msg0, exp0, mod0};
      pf1  <= {msg1, exp1, mod1};
    end
  end

  // Reference: payload byte k occupies byte k of the field word (order 0),
  // or byte P-1-k counted from the LSB (order 1).
  function automatic logic [23:0] model(input logic [7:0] b0, b1, b2, input bit order);
    logic [7:0] p[3];
    logic [23:0] v;
    p[0] = b0; p[1] = b1; p[2] = b2;
    v = '0;
    for (int k = 0; k < 3; k++) begin
      if (order) v = (v << 8) | 24'(p[k]);
      else       v = v + (24'(p[k]) << (8 * k));
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) tick();
    end
    rx = 1'b1;
    repeat (10) tick();
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, input logic [7:0] flip);
    send_byte(8'hA5);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b0 ^ b1 ^ b2 ^ flip);
    repeat (20) tick();
  endtask

  task automatic check_result(input string tag, input int n_acc, input logic [23:0] e0, e1,
                              input int n_err, input logic [1:0] code);
    chk({tag, "_nacc0"}, acc0.size(), n_acc);
    chk({tag, "_nacc1"}, acc1.size(), n_acc);
    if (n_acc == 1 && acc0.size() == 1) chk({tag, "_fields0"}, acc0[0], e0);
    if (n_acc == 1 && acc1.size() == 1) chk({tag, "_fields1"}, acc1[0], e1);
    chk({tag, "_nerr0"}, errq0.size(), n_err);
    chk({tag, "_nerr1"}, errq1.size(), n_err);
    if (n_err == 1 && errq0.size() == 1) chk({tag, "_code0"}, errq0[0], code);
    if (n_err == 1 && errq1.size() == 1) chk({tag, "_code1"}, errq1[0], code);
    if (n_err == 1) begin
      chk({tag, "_held0"}, code0, code);
      chk({tag, "_held1"}, code1, code);
    end
    acc0.delete(); acc1.delete(); errq0.delete(); errq1.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out0"}, {vld0, msg0, exp0, mod0, err0, code0}, 0);
    chk({tag, "_out1"}, {vld1, msg1, exp1, mod1, err1, code1}, 0);
  endtask

  initial begin
    logic [7:0] a0, a1, a2, b0, b1, b2, flip;
    int nj;
    bit bad;

    repeat (5) tick();
    check_zero("reset");
    rst = 1'b0;
    repeat (5) tick();

    // Reference frame with both byte orders.
    send_frame(8'h11, 8'h22, 8'h33, 8'h00);
    check_result("basic", 1, 24'h332211, 24'h112233, 0, 2'd0);

    // Bad checksum, then a good frame.
    send_frame(8'h11, 8'h22, 8'h33, 8'hCC);
    check_result("csum", 0, '0, '0, 1, 2'd2);
    send_frame(8'h01, 8'h02, 8'h03, 8'h00);
    check_result("after_csum", 1, model(8'h01, 8'h02, 8'h03, 0), model(8'h01, 8'h02, 8'h03, 1),
                 0, 2'd0);

    // Inter-byte timeout, then recovery.
    send_byte(8'hA5);
    send_byte(8'h11);
    repeat (2300) tick();
    check_result("timeout", 0, '0, '0, 1, 2'd1);
    send_frame(8'h44, 8'h55, 8'h66, 8'h00);
    check_result("after_to", 1, 24'h665544, 24'h445566, 0, 2'd0);

    // Randomized frames with junk prefixes and occasional corrupt checksums.
    for (int f = 0; f < 16; f++) begin
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        b0 = 8'($urandom_range(0, 255));
        if (b0 == 8'hA5) b0 = 8'h5A;
        send_byte(b0);
      end
      a0 = 8'($urandom_range(0, 255));
      a1 = 8'($urandom_range(0, 255));
      a2 = 8'($urandom_range(0, 255));
      bad  = ($urandom_range(0, 3) == 0);
      flip = bad ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(a0, a1, a2, flip);
      check_result("rand", bad ? 0 : 1, model(a0, a1, a2, 0), model(a0, a1, a2, 1),
                   bad ? 1 : 0, 2'd2);
    end

    // Backpressure: A held, B dropped with overflow, then A accepted.
    a0 = 8'h1A; a1 = 8'h2B; a2 = 8'h3C;
    rdy = 1'b0;
    send_frame(a0, a1, a2, 8'h00);
    send_frame(8'h77, 8'h88, 8'h99, 8'h00);
    check_result("ovf", 0, '0, '0, 1, 2'd3);
    chk("ovf_vld0", vld0, 1);
    chk("ovf_vld1", vld1, 1);
    chk("ovf_f0", {msg0, exp0, mod0}, model(a0, a1, a2, 0));
    chk("ovf_f1", {msg1, exp1, mod1}, model(a0, a1, a2, 1));
    rdy = 1'b1;
    repeat (3) tick();
    check_result("ovf_acc", 1, model(a0, a1, a2, 0), model(a0, a1, a2, 1), 0, 2'd0);
    chk("ovf_fall0", vld0, 0);
    chk("ovf_fall1", vld1, 0);

    // Asynchronous reset in the middle of a payload byte.
    send_byte(8'hA5);
    send_byte(8'h11);
    rx = 1'b0;
    repeat (15) tick();
    #2 rst = 1'b1;
    #1;
    check_zero("midrst");
    rx = 1'b1;
    repeat (20) tick();
    rst = 1'b0;
    repeat (20) tick();
    acc0.delete(); acc1.delete(); errq0.delete(); errq1.delete();
    send_byte(8'h00);
    send_byte(8'h7E);
    b0 = 8'h5A; b1 = 8'h3C; b2 = 8'hC3;
    send_frame(b0, b1, b2, 8'h00);
    check_result("post_rst", 1, model(b0, b1, b2, 0), model(b0, b1, b2, 1), 0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
